// File: rtl/spi_target_framer.sv
// SPI mode-0 target front end: synchronises SCLK/CS_N/MOSI into clk, deserialises
// MOSI into WIDTH-bit words behind a one-entry valid/ready register, and serialises TX words onto MISO.
`timescale 1ns/1ps

module spi_target_framer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             spi_sclk,
  input  logic             spi_cs_n,
  input  logic             spi_mosi,
  output logic             spi_miso,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic             rx_overflow,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             frame_active
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic {ST_IDLE, ST_ACTIVE} state_e;

  // [0],[1] are the synchroniser stages, [2] is the history stage for edge detection.
  logic [2:0]       r_sclk_sync;
  logic [2:0]       r_cs_sync;
  logic [2:0]       r_mosi_sync;
  logic [1:0]       r_warm;
  logic             r_armed;
  state_e           r_state;
  logic [CW-1:0]    r_bit_cnt;
  logic [WIDTH-1:0] r_rx_shift;
  logic [WIDTH-1:0] r_tx_shift;
  logic [WIDTH-1:0] r_rx_data;
  logic             r_rx_valid;
  logic             r_rx_overflow;
  logic             r_miso;

  logic             w_sclk_rise;
  logic             w_sclk_fall;
  logic             w_cs_fall;
  logic             w_cs_rise;
  logic             w_start;
  logic             w_in_frame;
  logic             w_reload;
  logic             w_word_done;
  logic [WIDTH-1:0] w_rx_word;
  logic [WIDTH-1:0] w_tx_load;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sclk_sync <= 3'b000;
      r_cs_sync   <= 3'b111;
      r_mosi_sync <= 3'b000;
      r_warm      <= 2'b00;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
      r_sclk_sync <= {r_sclk_sync[1:0], spi_sclk};
      r_cs_sync   <= {r_cs_sync[1:0], spi_cs_n};
      r_mosi_sync <= {r_mosi_sync[1:0], spi_mosi};
      r_warm      <= {r_warm[0], 1'b1};
    end
  end

  assign w_sclk_rise = r_sclk_sync[1] & ~r_sclk_sync[2];
  assign w_sclk_fall = ~r_sclk_sync[1] & r_sclk_sync[2];
  assign w_cs_fall   = ~r_cs_sync[1] & r_cs_sync[2];
  assign w_cs_rise   = r_cs_sync[1] & ~r_cs_sync[2];

  // A CS_N held low through reset release must not look like a fresh falling edge.
  assign w_start     = (r_state == ST_IDLE) && w_cs_fall && r_armed;
  assign w_in_frame  = (r_state == ST_ACTIVE) && !w_cs_rise;
  assign w_reload    = w_start || (w_in_frame && w_sclk_fall && (r_bit_cnt == '0));
  assign w_word_done = w_in_frame && w_sclk_rise && (r_bit_cnt == LAST_BIT);
  // MOSI is stable around the SCLK rising edge in mode 0, so the history stage is a safe sample.
  assign w_rx_word   = {r_rx_shift[WIDTH-2:0], r_mosi_sync[2]};
  assign w_tx_load   = tx_valid ? tx_data : '0;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_armed       <= 1'b0;
      r_state       <= ST_IDLE;
      r_bit_cnt     <= '0;
      r_rx_shift    <= '0;
      r_tx_shift    <= '0;
      r_rx_data     <= '0;
      r_rx_valid    <= 1'b0;
      r_rx_overflow <= 1'b0;
      r_miso        <= 1'b0;
    end else begin
      r_rx_overflow <= 1'b0;
      r_miso        <= (r_state == ST_ACTIVE) ? r_tx_shift[WIDTH-1] : 1'b0;

      if (r_warm[1] && r_cs_sync[1]) r_armed <= 1'b1;
      if (r_rx_valid && rx_ready) r_rx_valid <= 1'b0;
      if (w_reload) r_tx_shift <= w_tx_load;

      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state   <= ST_ACTIVE;
            r_bit_cnt <= '0;
          end
        end
        ST_ACTIVE: begin
          if (w_cs_rise) begin
            r_state   <= ST_IDLE;
            r_bit_cnt <= '0;
          end else if (w_sclk_rise) begin
            r_rx_shift <= w_rx_word;
            r_bit_cnt  <= (r_bit_cnt == LAST_BIT) ? '0 : r_bit_cnt + CW'(1);
          end else if (w_sclk_fall && (r_bit_cnt != '0)) begin
            r_tx_shift <= {r_tx_shift[WIDTH-2:0], 1'b0};
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      if (w_word_done) begin
        if (!r_rx_valid || rx_ready) begin
          r_rx_data  <= w_rx_word;
          r_rx_valid <= 1'b1;
        end else begin
          r_rx_overflow <= 1'b1;
        end
      end
    end
  end

  // tx_ready is decoded from flops so it is high in the very cycle tx_data is captured.
  assign tx_ready     = w_reload;
  assign spi_miso     = r_miso;
  assign rx_data      = r_rx_data;
  assign rx_valid     = r_rx_valid;
  assign rx_overflow  = r_rx_overflow;
  assign frame_active = (r_state == ST_ACTIVE);

endmodule

// File: tb/tb_spi_target_framer.sv
// Self-checking bench for spi_target_framer: table-driven frames, directed corner cases
// and randomised frames compared against a word-level reference model.
`timescale 1ns/1ps

module tb_spi_target_framer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic         spi_sclk = 1'b0;
  logic         spi_cs_n = 1'b1;
  logic         spi_mosi = 1'b0;
  logic         rx_ready = 1'b0;
  logic         spi_miso;
  logic [W-1:0] rx_data;
  logic         rx_valid;
  logic         rx_overflow;
  logic [W-1:0] tx_data;
  logic         tx_valid;
  logic         tx_ready;
  logic         frame_active;

  spi_target_framer #(.WIDTH(W)) dut (
    .clk(clk), .rstn(rstn),
    .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_overflow(rx_overflow),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .frame_active(frame_active)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // TX producer: presents tx_words[tx_idx], advances after each tx_ready handshake.
  logic [7:0] tx_words[512];
  logic       tx_vld[512];
  int         tx_idx = 0;
  bit         tx_adv = 1'b0;
  int         tx_pulses = 0;

  always @(negedge clk) begin
    if (tx_adv) tx_idx = (tx_idx + 1) % 512;
    tx_adv = tx_ready;
    if (tx_ready) tx_pulses++;
    tx_data  = tx_words[tx_idx];
    tx_valid = tx_vld[tx_idx];
  end

  // RX consumer monitor: logs accepted words and overflow pulses.
  logic [7:0] rx_got[256];
  int         rx_cnt = 0;
  int         ovf_cnt = 0;

  always @(negedge clk) begin
    if (rx_valid && rx_ready) begin
      rx_got[rx_cnt % 256] = rx_data;
      rx_cnt++;
    end
    if (rx_overflow) ovf_cnt++;
  end

  // Frame driver state.
  logic [7:0] f_mosi[3];
  logic [7:0] f_miso[3];
  int         f_lat, f_txp, f_rx0, f_ovf0;
  logic       f_fa;
  bit         f_pulse_ready = 1'b0;

  task automatic wait_clk(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic setup_tx(input int n, input logic [2:0][7:0] d, input logic [2:0] v);
    for (int k = 0; k < n; k++) begin
      tx_words[(tx_idx + k) % 512] = d[k];
      tx_vld[(tx_idx + k) % 512]   = v[k];
    end
    tx_words[(tx_idx + n) % 512] = 8'h00;
    tx_vld[(tx_idx + n) % 512]   = 1'b0;
  endtask

  task automatic sclk_bit(input logic b);
    spi_mosi = b;
    wait_clk(4);
    spi_sclk = 1'b1;
    wait_clk(4);
    spi_sclk = 1'b0;
  endtask

  // Runs one CS frame of n words; abort_bits>0 raises CS after that many bits.
  task automatic run_frame(input int n, input int abort_bits);
    int         bits;
    int         txp0;
    logic [7:0] cap;
    bit         stop;
    bits = 0;
    stop = 1'b0;
    txp0 = tx_pulses;
    f_rx0 = rx_cnt;
    f_ovf0 = ovf_cnt;
    f_lat = -1;
    f_txp = -1;
    spi_cs_n = 1'b0;
    wait_clk(6);
    f_fa = frame_active;
    for (int w = 0; w < n && !stop; w++) begin
      cap = 8'h00;
      for (int b = 7; b >= 0; b--) begin
        spi_mosi = f_mosi[w][b];
        wait_clk(4);
        cap = {cap[6:0], spi_miso};
        spi_sclk = 1'b1;
        bits++;
        if (w == n - 1 && b == 0) begin
          for (int k = 1; k <= 4; k++) begin
            wait_clk(1);
            if (f_pulse_ready && k == 2) rx_ready = 1'b1;
            if (f_pulse_ready && k == 3) rx_ready = 1'b0;
            if (f_lat < 0 && rx_valid) f_lat = k;
          end
          f_txp = tx_pulses - txp0;
        end else begin
          wait_clk(4);
        end
        spi_sclk = 1'b0;
        if (abort_bits > 0 && bits == abort_bits) begin
          stop = 1'b1;
          break;
        end
      end
      f_miso[w] = cap;
    end
    wait_clk(4);
    spi_cs_n = 1'b1;
    spi_mosi = 1'b0;
    wait_clk(8);
  endtask

  // Reference model: with rx_ready held high every MOSI word is delivered in order,
  // each MISO word is the offered tx word or zero, and one tx_ready precedes each word.
  task automatic check_frame(input string tag, input int n, input logic [2:0][7:0] mosi,
                             input logic [2:0][7:0] txd, input logic [2:0] txv);
    check({tag, " frame_active"}, f_fa, 1'b1);
    check({tag, " rx count"}, rx_cnt - f_rx0, n);
    for (int w = 0; w < n; w++) begin
      check($sformatf("%s rx_data[%0d]", tag, w), rx_got[(f_rx0 + w) % 256], mosi[w]);
      check($sformatf("%s miso[%0d]", tag, w), f_miso[w], txv[w] ? txd[w] : 8'h00);
    end
    check({tag, " tx_ready pulses"}, f_txp, n);
    check({tag, " rx_valid latency ok"}, (f_lat >= 1 && f_lat <= 4), 1'b1);
    check({tag, " overflow"}, ovf_cnt - f_ovf0, 0);
  endtask

  typedef struct packed {
    logic [1:0]      n;
    logic [2:0][7:0] mosi;
    logic [2:0][7:0] txd;
    logic [2:0]      txv;
    logic [2:0][7:0] exp_miso;
  } vec_t;

  function automatic vec_t mk(input int n, input logic [7:0] m0, m1, m2,
                              input logic [7:0] t0, t1, t2, input logic [2:0] v,
                              input logic [7:0] e0, e1, e2);
    vec_t r;
    r.n = 2'(n);
    r.mosi = {m2, m1, m0};
    r.txd = {t2, t1, t0};
    r.txv = v;
    r.exp_miso = {e2, e1, e0};
    return r;
  endfunction

  vec_t vecs[4];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0][7:0] rm, rt;
    logic [2:0]      rv;
    int              rn;

    for (int i = 0; i < 512; i++) begin
      tx_words[i] = 8'h00;
      tx_vld[i] = 1'b0;
    end

    vecs[0] = mk(1, 8'hA5, 8'h00, 8'h00, 8'h3C, 8'h00, 8'h00, 3'b001, 8'h3C, 8'h00, 8'h00);
    vecs[1] = mk(3, 8'h01, 8'h80, 8'hFF, 8'hAA, 8'h55, 8'hC3, 3'b101, 8'hAA, 8'h00, 8'hC3);
    vecs[2] = mk(2, 8'h7E, 8'h81, 8'h00, 8'h00, 8'hFF, 8'h00, 3'b011, 8'h00, 8'hFF, 8'h00);
    vecs[3] = mk(3, 8'h00, 8'hFF, 8'h5A, 8'h12, 8'h34, 8'h56, 3'b000, 8'h00, 8'h00, 8'h00);

    // Reset values, during and after reset.
    wait_clk(3);
    check("reset miso", spi_miso, 1'b0);
    check("reset rx_valid", rx_valid, 1'b0);
    check("reset tx_ready", tx_ready, 1'b0);
    rstn = 1'b1;
    wait_clk(4);
    check("post-reset rx_data", rx_data, 8'h00);
    check("post-reset rx_valid", rx_valid, 1'b0);
    check("post-reset rx_overflow", rx_overflow, 1'b0);
    check("post-reset tx_ready", tx_ready, 1'b0);
    check("post-reset frame_active", frame_active, 1'b0);
    check("post-reset miso", spi_miso, 1'b0);

    // Table-driven frames with the consumer always ready.
    rx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      setup_tx(vecs[i].n, vecs[i].txd, vecs[i].txv);
      for (int w = 0; w < 3; w++) f_mosi[w] = vecs[i].mosi[w];
      run_frame(vecs[i].n, 0);
      check($sformatf("vec%0d rx count", i), rx_cnt - f_rx0, vecs[i].n);
      for (int w = 0; w < int'(vecs[i].n); w++) begin
        check($sformatf("vec%0d rx_data[%0d]", i, w), rx_got[(f_rx0 + w) % 256], vecs[i].mosi[w]);
        check($sformatf("vec%0d miso[%0d]", i, w), f_miso[w], vecs[i].exp_miso[w]);
      end
      check($sformatf("vec%0d tx_ready pulses", i), f_txp, vecs[i].n);
      check($sformatf("vec%0d rx_valid latency ok", i), (f_lat >= 1 && f_lat <= 4), 1'b1);
      check($sformatf("vec%0d overflow", i), ovf_cnt - f_ovf0, 0);
      check($sformatf("vec%0d frame_active", i), f_fa, 1'b1);
    end
    rx_ready = 1'b0;

    // Overflow: second word dropped while the first is unconsumed.
    f_mosi[0] = 8'h11;
    f_mosi[1] = 8'h22;
    run_frame(2, 0);
    check("ovf rx_data", rx_data, 8'h11);
    check("ovf rx_valid", rx_valid, 1'b1);
    check("ovf pulses", ovf_cnt - f_ovf0, 1);
    f_rx0 = rx_cnt;
    rx_ready = 1'b1;
    wait_clk(1);
    rx_ready = 1'b0;
    wait_clk(1);
    check("ovf drained rx_valid", rx_valid, 1'b0);
    check("ovf drained word", rx_got[f_rx0 % 256], 8'h11);

    // Aborted word, then a clean frame.
    f_mosi[0] = 8'hFF;
    run_frame(1, 5);
    check("abort rx_valid", rx_valid, 1'b0);
    check("abort overflow", ovf_cnt - f_ovf0, 0);
    check("abort frame_active", frame_active, 1'b0);
    f_mosi[0] = 8'h5A;
    run_frame(1, 0);
    check("after abort rx_data", rx_data, 8'h5A);
    check("after abort rx_valid", rx_valid, 1'b1);
    rx_ready = 1'b1;
    wait_clk(2);
    rx_ready = 1'b0;

    // Accept in the exact cycle the second word completes.
    f_mosi[0] = 8'h33;
    f_mosi[1] = 8'hCC;
    f_pulse_ready = 1'b1;
    run_frame(2, 0);
    f_pulse_ready = 1'b0;
    check("simul rx_valid", rx_valid, 1'b1);
    check("simul rx_data", rx_data, 8'hCC);
    check("simul overflow", ovf_cnt - f_ovf0, 0);
    check("simul accepted first", rx_got[(rx_cnt - 1) % 256], 8'h33);
    rx_ready = 1'b1;
    wait_clk(2);
    rx_ready = 1'b0;

    // Reset mid-frame with a word pending, CS held low across reset release.
    f_mosi[0] = 8'hE7;
    run_frame(1, 0);
    check("pre-reset pending", rx_valid, 1'b1);
    spi_cs_n = 1'b0;
    wait_clk(6);
    for (int b = 0; b < 4; b++) sclk_bit(b[0]);
    rstn = 1'b0;
    wait_clk(1);
    check("midreset rx_valid", rx_valid, 1'b0);
    check("midreset rx_data", rx_data, 8'h00);
    check("midreset frame_active", frame_active, 1'b0);
    check("midreset miso", spi_miso, 1'b0);
    check("midreset tx_ready", tx_ready, 1'b0);
    rstn = 1'b1;
    wait_clk(4);
    for (int b = 7; b >= 0; b--) sclk_bit(b[0] ^ b[1]);
    wait_clk(4);
    check("held-cs frame_active", frame_active, 1'b0);
    check("held-cs rx_valid", rx_valid, 1'b0);
    spi_cs_n = 1'b1;
    wait_clk(8);
    f_mosi[0] = 8'h96;
    run_frame(1, 0);
    check("post-reset frame rx_data", rx_data, 8'h96);
    check("post-reset frame rx_valid", rx_valid, 1'b1);
    rx_ready = 1'b1;
    wait_clk(2);

    // Randomised frames against the word-level model, consumer always ready.
    for (int i = 0; i < 25; i++) begin
      rn = $urandom_range(1, 3);
      for (int w = 0; w < 3; w++) begin
        rm[w] = 8'($urandom);
        rt[w] = 8'($urandom);
        rv[w] = 1'($urandom);
        f_mosi[w] = rm[w];
      end
      setup_tx(rn, rt, rv);
      run_frame(rn, 0);
      check_frame($sformatf("rand%0d", i), rn, rm, rt, rv);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
